// File: rtl/sel_pipe_mux.sv
// sel_pipe_mux: N-way WIDTH-bit selector feeding a DEPTH-stage registered pipeline with valid tracking.
// Ports: clk/rst_n (async active-low), in_valid/sel/opts in, en (advance), flush (clear), err_clr;
//        comb_result (combinational select), out_data/out_valid (last stage), err/err_cnt (illegal select).
// Latency DEPTH enabled edges; en=0 stalls every stage, flush clears every stage and beats en.
// Optional macro SEL_PIPE_MUX_ERR_EN builds the sticky err flag and saturating 8-bit err_cnt;
// without it err/err_cnt are tied to 0 and err_clr is ignored.
module sel_pipe_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int DEPTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] opts,
  input  logic               en,
  input  logic               flush,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   comb_result,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               err,
  output logic [7:0]         err_cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] stg_dat;
  logic [DEPTH-1:0]            stg_vld;

  // Out-of-range selects fall through every comparison and leave the zero default.
  always_comb begin
    comb_result = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        comb_result = opts[k*WIDTH +: WIDTH];
      end
    end
  end

  // Data of invalid entries is still captured; only flush/reset force it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dat <= '0;
      stg_vld <= '0;
    end else if (flush) begin
      stg_dat <= '0;
      stg_vld <= '0;
    end else if (en) begin
      stg_dat[0] <= comb_result;
      stg_vld[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stg_dat[i] <= stg_dat[i-1];
        stg_vld[i] <= stg_vld[i-1];
      end
    end
  end

  assign out_data  = stg_dat[DEPTH-1];
  assign out_valid = stg_vld[DEPTH-1];

`ifdef SEL_PIPE_MUX_ERR_EN
  logic illegal_sel;
  logic err_evt;

  assign illegal_sel = (32'(sel) >= 32'(N));
  assign err_evt     = in_valid & en & ~flush & illegal_sel;

  // An event on the same edge as err_clr wins: the count restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else if (err_evt) begin
      err <= 1'b1;
      if (err_clr) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (err_clr) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end
  end
`else
  logic err_clr_unused;

  assign err_clr_unused = err_clr;
  assign err            = 1'b0;
  assign err_cnt        = 8'd0;
`endif

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Bench for sel_pipe_mux: instance u_a (N=4, DEPTH=1) and u_b (N=3, DEPTH=3) share stimulus.
// Expected outputs are queued when stimulus is issued; a monitor pops on every advancing edge with out_valid=1.
module tb_sel_pipe_mux;

`ifdef SEL_PIPE_MUX_ERR_EN
  localparam logic [31:0] ERR_EN = 32'd1;
`else
  localparam logic [31:0] ERR_EN = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   sel;
  logic [127:0] opts;
  logic         en;
  logic         flush;
  logic         err_clr;

  logic [31:0]  comb_result_a, out_data_a, comb_result_b, out_data_b;
  logic         out_valid_a, err_a, out_valid_b, err_b;
  logic [7:0]   err_cnt_a, err_cnt_b;

  logic [31:0]  opt_tab [4];
  logic [31:0]  q_a [$];
  logic [31:0]  q_b [$];
  int           errors = 0;
  int           checks = 0;
  bit           adv_m;

  always #5 clk = ~clk;

  sel_pipe_mux #(.WIDTH(32), .N(4), .SEL_W(2), .DEPTH(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .opts(opts),
    .en(en), .flush(flush), .err_clr(err_clr), .comb_result(comb_result_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .err(err_a), .err_cnt(err_cnt_a));

  sel_pipe_mux #(.WIDTH(32), .N(3), .SEL_W(2), .DEPTH(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sel(sel), .opts(opts[95:0]),
    .en(en), .flush(flush), .err_clr(err_clr), .comb_result(comb_result_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .err(err_b), .err_cnt(err_cnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_a(input logic [1:0] s);
    return opt_tab[s];
  endfunction

  function automatic logic [31:0] exp_b(input logic [1:0] s);
    return (s < 2'd3) ? opt_tab[s] : 32'd0;
  endfunction

  // Drive one cycle of stimulus at the falling edge, then return just after the next rising edge.
  task automatic cyc(input bit v, input logic [1:0] s, input bit e, input bit f, input bit c);
    @(negedge clk);
    opts     = {opt_tab[3], opt_tab[2], opt_tab[1], opt_tab[0]};
    in_valid = v;
    sel      = s;
    en       = e;
    flush    = f;
    err_clr  = c;
    if (f) begin
      q_a.delete();
      q_b.delete();
    end else if (v && e) begin
      q_a.push_back(exp_a(s));
      q_b.push_back(exp_b(s));
    end
    @(posedge clk);
    #2;
  endtask

  // Monitor: only an advancing edge presents a new entry on out_*.
  initial begin
    forever begin
      @(posedge clk);
      adv_m = rst_n && en && !flush;
      #1;
      if (adv_m && out_valid_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected: got out_valid=1 data %h expected no entry", out_data_a);
        end else chk("a_data", out_data_a, q_a.pop_front());
      end
      if (adv_m && out_valid_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: got out_valid=1 data %h expected no entry", out_data_b);
        end else chk("b_data", out_data_b, q_b.pop_front());
      end
    end
  end

  initial begin
    opt_tab[0] = 32'hAAAA0000; opt_tab[1] = 32'hBBBB0001;
    opt_tab[2] = 32'hCCCC0002; opt_tab[3] = 32'hDDDD0003;
    opts = {opt_tab[3], opt_tab[2], opt_tab[1], opt_tab[0]};
    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; en = 1'b0; flush = 1'b0; err_clr = 1'b0;

    // Reset state
    #12;
    chk("rst_valid_a", 32'(out_valid_a), 32'd0);
    chk("rst_data_a", out_data_a, 32'd0);
    chk("rst_valid_b", 32'(out_valid_b), 32'd0);
    chk("rst_err_b", 32'(err_b), 32'd0);
    chk("rst_cnt_b", 32'(err_cnt_b), 32'd0);
    chk("rst_comb_a", comb_result_a, 32'hAAAA0000);
    @(negedge clk); rst_n = 1'b1;

    // Select sweep, one cycle latency on u_a
    for (int s = 0; s < 4; s++) begin
      cyc(1'b1, 2'(s), 1'b1, 1'b0, 1'b0);
      chk($sformatf("sweep_comb_a%0d", s), comb_result_a, exp_a(2'(s)));
      chk($sformatf("sweep_comb_b%0d", s), comb_result_b, exp_b(2'(s)));
      chk($sformatf("sweep_valid_a%0d", s), 32'(out_valid_a), 32'd1);
      chk($sformatf("sweep_data_a%0d", s), out_data_a, exp_a(2'(s)));
    end
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("drain_valid_b", 32'(out_valid_b), 32'd0);

    // Latency with stall on u_b (DEPTH=3): entry appears after the third enabled edge
    opt_tab[0] = 32'h11;
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("lat_e0_valid_b", 32'(out_valid_b), 32'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("lat_e1_valid_b", 32'(out_valid_b), 32'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("lat_e2_valid_b", 32'(out_valid_b), 32'd0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("lat_e3_valid_b", 32'(out_valid_b), 32'd0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("lat_e4_valid_b", 32'(out_valid_b), 32'd1);
    chk("lat_e4_data_b", out_data_b, 32'h11);
    opt_tab[0] = 32'hAAAA0000;

    // Flush beats en with three valid entries in flight
    cyc(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    chk("flush_valid_a", 32'(out_valid_a), 32'd0);
    chk("flush_data_a", out_data_a, 32'd0);
    chk("flush_valid_b", 32'(out_valid_b), 32'd0);
    chk("flush_data_b", out_data_b, 32'd0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("flush_hold_data_b", out_data_b, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("flush_empty_b%0d", i), 32'(out_valid_b), 32'd0);
    end
    // Flush while stalled
    cyc(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    chk("stall_flush_valid_a", 32'(out_valid_a), 32'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("stall_flush_valid_b", 32'(out_valid_b), 32'd0);

    // Illegal select on u_b (N=3)
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    chk("ill_comb_b", comb_result_b, 32'd0);
    chk("ill_err_b", 32'(err_b), ERR_EN);
    chk("ill_cnt_b", 32'(err_cnt_b), ERR_EN);
    chk("ill_err_a", 32'(err_a), 32'd0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("ill_out_valid_b", 32'(out_valid_b), 32'd1);
    chk("ill_out_data_b", out_data_b, 32'd0);
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
      if (i == 99) chk("ill_cnt_101", 32'(err_cnt_b), ERR_EN * 32'd101);
    end
    chk("ill_cnt_sat", 32'(err_cnt_b), ERR_EN * 32'd255);
    chk("ill_cnt_a", 32'(err_cnt_a), 32'd0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
    chk("clr_evt_err_b", 32'(err_b), ERR_EN);
    chk("clr_evt_cnt_b", 32'(err_cnt_b), ERR_EN);
    cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("clr_err_b", 32'(err_b), 32'd0);
    chk("clr_cnt_b", 32'(err_cnt_b), 32'd0);

    // Asynchronous reset mid-stream
    cyc(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_valid_a", 32'(out_valid_a), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd2;
    q_a.delete(); q_b.delete();
    #1;
    chk("mid_rst_valid_a", 32'(out_valid_a), 32'd0);
    chk("mid_rst_data_a", out_data_a, 32'd0);
    chk("mid_rst_valid_b", 32'(out_valid_b), 32'd0);
    chk("mid_rst_err_b", 32'(err_b), 32'd0);
    chk("mid_rst_cnt_b", 32'(err_cnt_b), 32'd0);
    chk("mid_rst_comb_a", comb_result_a, 32'hCCCC0002);
    @(negedge clk); rst_n = 1'b1;

    // Post-reset traffic and final drain
    cyc(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("post_rst_data_a", out_data_a, 32'hBBBB0001);
    for (int i = 0; i < 4; i++) cyc(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("end_queue_a", 32'(q_a.size()), 32'd0);
    chk("end_queue_b", 32'(q_b.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sel_pipe_mux.md
# sel_pipe_mux

Parametrised N-way, WIDTH-bit selector with a DEPTH-stage registered output pipeline, valid tracking, stall and flush. It is the successor of the fixed 2- and 4-way combinational selectors in the P5 datapath. It serves as the forwarding/result select feeding a pipeline register boundary, with illegal-select detection.

## Interface
Parameters:
- WIDTH, 32, data width of each option and of the result
- N, 4, number of options (2..16)
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N
- DEPTH, 1, number of output register stages (1..4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  current select/option set is valid
- sel  input  SEL_W  option index
- opts  input  N*WIDTH  flattened options; option k at bits [k*WIDTH +: WIDTH]
- en  input  1  pipeline advance; 0 = stall (all stages hold)
- flush  input  1  clear all stages
- err_clr  input  1  clear error flag and counter
- comb_result  output  WIDTH  combinational selected option (0 if sel >= N)
- out_data  output  WIDTH  last-stage data
- out_valid  output  1  last-stage valid
- err  output  1  sticky illegal-select flag (see Configuration)
- err_cnt  output  8  saturating illegal-select count (see Configuration)

## Operation
- Select: comb_result = opts[sel*WIDTH +: WIDTH] when sel < N, else all zeros. Pure combinational; no clock dependency.
- Stage 0 captures {in_valid, comb_result}. Stage i captures stage i-1. out_* = stage DEPTH-1.
- Per-edge priority: flush > en > hold.
  - flush=1: all stage valids and data go to 0, regardless of en.
  - flush=0, en=1: all stages shift.
  - flush=0, en=0: all stages hold.
- Data of an invalid entry is still captured; the bench checks out_data only when out_valid=1, except after reset/flush (must be 0).
- Illegal select event = in_valid & en & ~flush & (sel >= N). The zero result is still pushed with valid=1.
- err/err_cnt:
  - An event sets err and increments err_cnt, saturating at 255.
  - err_clr=1 zeroes both.
  - err_clr concurrent with an event: the event wins, giving err=1, err_cnt=1.
- No state machine beyond the shift pipeline and error counter.

## Timing
- Reset (rst_n=0, async, immediate): all stage data=0, valids=0, out_data=0, out_valid=0, err=0, err_cnt=0. comb_result follows inputs even in reset.
- Reset deassertion is not synchronised inside the block; the integrator provides a synchronous release.
- Latency: an input accepted at edge t (en=1) appears on out_* after edge t+DEPTH-1. It is visible in the cycle following edge t for DEPTH=1, and after DEPTH accepted edges in general. Stall cycles add one cycle each.
- Throughput: one entry per cycle while en=1.
- Flush mid-stall: clears everything; no entry survives.
- Reset mid-operation: all in-flight entries are lost; outputs are 0 asynchronously.
- err/err_cnt update at the same edge as the event; they are visible the next cycle.

## Configuration
- Macro SEL_PIPE_MUX_ERR_EN.
- Defined: the err flag and 8-bit err_cnt logic are built as specified.
- Undefined: no error logic is built. err and err_cnt are constant 0, and err_clr is ignored. Select and pipeline behaviour are unchanged, including the 0 result for sel >= N.

## Test plan
- Reset: drive rst_n=0 mid-stream with out_valid=1 -> out_data=0, out_valid=0, err=0 immediately; comb_result still tracks sel/opts.
- Select sweep (WIDTH=32, N=4, DEPTH=1): opts={0xDDDD0003,0xCCCC0002,0xBBBB0001,0xAAAA0000}, sel=0..3 on consecutive en=1 cycles -> out_data=0xAAAA0000,0xBBBB0001,0xCCCC0002,0xDDDD0003, each one cycle after accept, with out_valid=1.
- Latency/stall (DEPTH=3): accept 0x11 at edge 0, hold en=0 for 2 edges, then en=1 -> 0x11 appears with out_valid=1 after a total of 3 enabled edges (edge 4); out_valid=0 before.
- Flush priority: flush=1 and en=1 on the same edge with 3 valid entries in flight -> next cycle out_valid=0, out_data=0, and all stages empty for the following DEPTH cycles.
- Illegal select (N=3, SEL_W=2, macro defined): sel=3, in_valid=1, en=1 -> comb_result=0, out_valid=1 with out_data=0, err=1, err_cnt=1. 300 further events -> err_cnt=255. err_clr together with an event -> err=1, err_cnt=1.
- Macro undefined: repeat the illegal-select stimulus -> out_data=0, out_valid=1, err=0, err_cnt=0.
